// File: rtl/pin_delay_pkg.sv
// Shared definitions for the pin-to-pin delay settle monitor.
package pin_delay_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int SYNC_STAGES = 2;

  // Zero-delay reference value of the AND-OR stage for stimulus {a,b,c,d}.
  function automatic logic aoi_expect(input logic [3:0] abcd);
    return (abcd[3] & abcd[2]) | (abcd[1] & abcd[0]);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit synchronizer bringing an asynchronous level into clk_in.
module sync_2ff
  import pin_delay_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_in,
  output logic q_out
);

  logic [SYNC_STAGES-1:0] sr;

  // Shift the asynchronous input through the synchronizer flops.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sr <= '0;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], d_in};
    end
  end

  assign q_out = sr[SYNC_STAGES-1];

endmodule

// File: rtl/aoi_settle_monitor.sv
// Counts clock cycles from each stimulus change until the delayed AND-OR
// output settles at its zero-delay value, or reports a timeout.
module aoi_settle_monitor
  import pin_delay_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MAX_SETTLE = 6,
  parameter int STABLE_N   = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             c_in,
  input  logic             d_in,
  input  logic             y_in,
  output logic             settle_valid_out,
  output logic [CNT_W-1:0] settle_cnt_out,
  output logic             timeout_out,
  output logic             expect_out,
  output logic             busy_out,
  output logic             retrig_out
);

  localparam int               RUN_W    = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_SETTLE);
  localparam logic [RUN_W-1:0] RUN_DONE = RUN_W'(STABLE_N);

  logic [3:0]       in_q, in_qq;
  logic             chg, exp_c, y_s;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_out_n;
  logic [RUN_W-1:0] run, run_n, run_inc;
  logic             exp_r, exp_n;
  logic             valid_n, to_n, retrig_n;

  // Stimulus capture and one-cycle history for change detection.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      in_q  <= '0;
      in_qq <= '0;
    end else begin
      in_q  <= {a_in, b_in, c_in, d_in};
      in_qq <= in_q;
    end
  end

  assign chg     = (in_q != in_qq);
  assign exp_c   = aoi_expect(in_q);
  assign run_inc = run + 1'b1;

  sync_2ff u_y_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   (y_in),
    .q_out  (y_s)
  );

  // FSM state, counters and registered result outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
      cnt              <= '0;
      run              <= '0;
      exp_r            <= 1'b0;
      settle_valid_out <= 1'b0;
      settle_cnt_out   <= '0;
      timeout_out      <= 1'b0;
      retrig_out       <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      run              <= run_n;
      exp_r            <= exp_n;
      settle_valid_out <= valid_n;
      settle_cnt_out   <= cnt_out_n;
      timeout_out      <= to_n;
      retrig_out       <= retrig_n;
    end
  end

  // Next-state logic: cnt tracks mismatching cycles, run tracks the current matching streak.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    run_n     = run;
    exp_n     = exp_r;
    valid_n   = 1'b0;
    to_n      = 1'b0;
    retrig_n  = 1'b0;
    cnt_out_n = settle_cnt_out;
    case (state)
      IDLE: begin
        if (chg) begin
          state_n = WAIT;
          exp_n   = exp_c;
          cnt_n   = '0;
          run_n   = '0;
        end
      end
      WAIT: begin
        if (chg) begin
          exp_n    = exp_c;
          cnt_n    = '0;
          run_n    = '0;
          retrig_n = 1'b1;
        end else if (y_s == exp_r) begin
          run_n = run_inc;
          if (run_inc == RUN_DONE) begin
            valid_n   = 1'b1;
            cnt_out_n = cnt;
            state_n   = IDLE;
          end
        end else begin
          run_n = '0;
          if (cnt == CNT_MAX) begin
            valid_n   = 1'b1;
            to_n      = 1'b1;
            cnt_out_n = cnt;
            state_n   = IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_out   = (state == WAIT);
  assign expect_out = exp_r;

endmodule
